// File: rtl/csr_pkg.sv
// Shared CSR address map, write-op encodings and small helpers for the
// machine-mode CSR unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [1:0] CSR_OP_RW   = 2'b00;
  localparam logic [1:0] CSR_OP_RS   = 2'b01;
  localparam logic [1:0] CSR_OP_RC   = 2'b10;
  localparam logic [1:0] CSR_OP_RSVD = 2'b11;

  function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                            input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_RW: csr_apply = wdata;
      CSR_OP_RS: csr_apply = old | wdata;
      CSR_OP_RC: csr_apply = old & ~wdata;
      default:   csr_apply = old;
    endcase
  endfunction

  function automatic logic csr_is_ro(input logic [11:0] addr);
    csr_is_ro = (addr == CSR_MVENDORID) || (addr == CSR_MARCHID) ||
                (addr == CSR_MHARTID);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves; a write to either half
// replaces that half and suppresses carry out of a written low half.
module csr_counter64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [31:0] lo_q, hi_q;
  logic        carry;

  assign carry = inc && (lo_q == 32'hFFFF_FFFF) && !wr_lo;
  assign count = {hi_q, lo_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= wr_lo ? wdata : lo_q + {31'b0, inc};
      hi_q <= wr_hi ? wdata : hi_q + {31'b0, carry};
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: status/trap registers, ID constants and optional
// cycle/instret counters, with trap > mret > CSR-write update priority.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MVENDORID    = 32'h7973_7978,
  parameter logic [31:0] MARCHID      = 32'd22060008,
  parameter logic [31:0] MHARTID      = 32'd0,
  parameter logic [31:0] MTVEC_RST    = 32'h0,
  parameter int          HAS_COUNTERS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        csr_rena_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        csr_wena_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_illegal_o,
  input  logic        trap_ena_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_ena_i,
  input  logic        retire_i,
  output logic [31:0] trap_vec_o,
  output logic [31:0] mret_pc_o
);

  logic        mie_q, mpie_q;
  logic [29:0] mtvec_q, mepc_q;
  logic [31:0] mcause_q;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [31:0] mstatus_val, wr_old, wr_new;
  logic        wr_legal, do_wr;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign trap_vec_o  = {mtvec_q, 2'b00};
  assign mret_pc_o   = {mepc_q, 2'b00};

  function automatic logic implemented(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
      CSR_MVENDORID, CSR_MARCHID, CSR_MHARTID: implemented = 1'b1;
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
        implemented = (HAS_COUNTERS != 0);
      default: implemented = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] value_of(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:   value_of = mstatus_val;
      CSR_MTVEC:     value_of = {mtvec_q, 2'b00};
      CSR_MEPC:      value_of = {mepc_q, 2'b00};
      CSR_MCAUSE:    value_of = mcause_q;
      CSR_MVENDORID: value_of = MVENDORID;
      CSR_MARCHID:   value_of = MARCHID;
      CSR_MHARTID:   value_of = MHARTID;
      CSR_MCYCLE:    value_of = cycle_cnt[31:0];
      CSR_MCYCLEH:   value_of = cycle_cnt[63:32];
      CSR_MINSTRET:  value_of = instret_cnt[31:0];
      CSR_MINSTRETH: value_of = instret_cnt[63:32];
      default:       value_of = 32'h0;
    endcase
  endfunction

  always_comb begin
    csr_rdata_o = 32'h0;
    if (csr_rena_i && implemented(csr_raddr_i)) csr_rdata_o = value_of(csr_raddr_i);
  end

  always_comb begin
    wr_old = value_of(csr_waddr_i);
    wr_new = csr_apply(csr_op_i, wr_old, csr_wdata_i);
  end

  assign wr_legal = implemented(csr_waddr_i) && !csr_is_ro(csr_waddr_i) &&
                    (csr_op_i != CSR_OP_RSVD);
  assign csr_illegal_o = (csr_rena_i && !implemented(csr_raddr_i)) ||
                         (csr_wena_i && !wr_legal);
  // Trap and mret both own the update path this cycle, so a coincident write is dropped.
  assign do_wr = csr_wena_i && wr_legal && !trap_ena_i && !mret_ena_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RST[31:2];
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_ena_i) begin
      mepc_q   <= trap_pc_i[31:2];
      mcause_q <= trap_cause_i;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret_ena_i) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (do_wr) begin
      case (csr_waddr_i)
        CSR_MSTATUS: begin
          mie_q  <= wr_new[3];
          mpie_q <= wr_new[7];
        end
        CSR_MTVEC:  mtvec_q  <= wr_new[31:2];
        CSR_MEPC:   mepc_q   <= wr_new[31:2];
        CSR_MCAUSE: mcause_q <= wr_new;
        default: ;
      endcase
    end
  end

  generate
    if (HAS_COUNTERS != 0) begin : g_cnt
      csr_counter64 u_mcycle (
        .clock (clock),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (do_wr && (csr_waddr_i == CSR_MCYCLE)),
        .wr_hi (do_wr && (csr_waddr_i == CSR_MCYCLEH)),
        .wdata (wr_new),
        .count (cycle_cnt)
      );
      csr_counter64 u_minstret (
        .clock (clock),
        .reset (reset),
        .inc   (retire_i),
        .wr_lo (do_wr && (csr_waddr_i == CSR_MINSTRET)),
        .wr_hi (do_wr && (csr_waddr_i == CSR_MINSTRETH)),
        .wdata (wr_new),
        .count (instret_cnt)
      );
    end else begin : g_nocnt
      assign cycle_cnt   = '0;
      assign instret_cnt = '0;
    end
  endgenerate

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expectations are queued as stimulus is
// applied and popped when the corresponding output is sampled.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        csr_rena_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        csr_wena_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_illegal_o;
  logic        trap_ena_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_cause_i;
  logic        mret_ena_i;
  logic        retire_i;
  logic [31:0] trap_vec_o;
  logic [31:0] mret_pc_o;

  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  csr_unit dut (
    .clock         (clock),
    .reset         (reset),
    .csr_rena_i    (csr_rena_i),
    .csr_raddr_i   (csr_raddr_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_wena_i    (csr_wena_i),
    .csr_op_i      (csr_op_i),
    .csr_waddr_i   (csr_waddr_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_illegal_o (csr_illegal_o),
    .trap_ena_i    (trap_ena_i),
    .trap_pc_i     (trap_pc_i),
    .trap_cause_i  (trap_cause_i),
    .mret_ena_i    (mret_ena_i),
    .retire_i      (retire_i),
    .trap_vec_o    (trap_vec_o),
    .mret_pc_o     (mret_pc_o)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Driver tasks; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%h but no expected entry queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic read_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    csr_rena_i  = 1'b1;
    csr_raddr_i = addr;
    #1;
    check(tag, csr_rdata_o);
    csr_rena_i = 1'b0;
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    csr_wena_i  = 1'b1;
    csr_waddr_i = addr;
    csr_op_i    = op;
    csr_wdata_i = data;
    tick();
    csr_wena_i = 1'b0;
  endtask

  logic [31:0] rnd;

  initial begin
    reset = 1'b1;
    csr_rena_i = 1'b0; csr_raddr_i = '0;
    csr_wena_i = 1'b0; csr_op_i = CSR_OP_RW; csr_waddr_i = '0; csr_wdata_i = '0;
    trap_ena_i = 1'b0; trap_pc_i = '0; trap_cause_i = '0;
    mret_ena_i = 1'b0; retire_i = 1'b0;
    tick();
    read_chk("reset_mcycle", CSR_MCYCLE, 32'h0);
    tick();
    reset = 1'b0;

    // Reset state
    read_chk("reset_mstatus", CSR_MSTATUS, 32'h0000_1800);
    read_chk("mvendorid", CSR_MVENDORID, 32'h7973_7978);
    exp_q.push_back(32'd0);
    csr_rena_i = 1'b1; csr_raddr_i = CSR_MARCHID; #1;
    check("reset_illegal", {31'b0, csr_illegal_o});
    csr_rena_i = 1'b0;
    read_chk("marchid", CSR_MARCHID, 32'd22060008);
    exp_q.push_back(32'h0); check("reset_trap_vec", trap_vec_o);
    exp_q.push_back(32'h0); check("reset_mret_pc", mret_pc_o);
    read_chk("reset_mcause", CSR_MCAUSE, 32'h0);

    // RW / RS / RC and low-bit masking
    write_csr(CSR_MTVEC, CSR_OP_RW, 32'h8000_0003);
    read_chk("mtvec_rw", CSR_MTVEC, 32'h8000_0000);
    exp_q.push_back(32'h8000_0000); check("trap_vec", trap_vec_o);
    write_csr(CSR_MSTATUS, CSR_OP_RS, 32'h8);
    read_chk("mstatus_rs", CSR_MSTATUS, 32'h0000_1808);
    write_csr(CSR_MSTATUS, CSR_OP_RC, 32'h8);
    read_chk("mstatus_rc", CSR_MSTATUS, 32'h0000_1800);
    write_csr(CSR_MSTATUS, CSR_OP_RW, 32'hFFFF_FFFF);
    read_chk("mstatus_mask", CSR_MSTATUS, 32'h0000_1888);
    write_csr(CSR_MSTATUS, CSR_OP_RW, 32'h0);
    rnd = $urandom();
    write_csr(CSR_MCAUSE, CSR_OP_RW, rnd);
    read_chk("mcause_rand", CSR_MCAUSE, rnd);

    // Trap with a concurrent write that must be dropped, then mret
    write_csr(CSR_MSTATUS, CSR_OP_RS, 32'h8);
    trap_ena_i = 1'b1; trap_pc_i = 32'h8000_0102; trap_cause_i = 32'd11;
    write_csr(CSR_MCAUSE, CSR_OP_RW, 32'hDEAD_BEEF);
    trap_ena_i = 1'b0;
    read_chk("trap_mepc", CSR_MEPC, 32'h8000_0100);
    read_chk("trap_mcause", CSR_MCAUSE, 32'd11);
    read_chk("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
    mret_ena_i = 1'b1;
    tick();
    mret_ena_i = 1'b0;
    read_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
    exp_q.push_back(32'h8000_0100); check("mret_pc", mret_pc_o);

    // Counter half writes and low-to-high carry
    write_csr(CSR_MCYCLE, CSR_OP_RW, 32'hFFFF_FFFE);
    write_csr(CSR_MCYCLEH, CSR_OP_RW, 32'h0);
    tick();
    read_chk("mcycleh_carry", CSR_MCYCLEH, 32'h1);
    read_chk("mcycle_wrap", CSR_MCYCLE, 32'h0);

    // Illegal accesses
    csr_wena_i = 1'b1; csr_waddr_i = CSR_MVENDORID; csr_op_i = CSR_OP_RW; csr_wdata_i = 32'h0;
    #1;
    exp_q.push_back(32'd1); check("illegal_ro_write", {31'b0, csr_illegal_o});
    tick();
    csr_wena_i = 1'b0;
    read_chk("mvendorid_kept", CSR_MVENDORID, 32'h7973_7978);
    csr_wena_i = 1'b1; csr_waddr_i = CSR_MCAUSE; csr_op_i = CSR_OP_RSVD; csr_wdata_i = 32'h5;
    #1;
    exp_q.push_back(32'd1); check("illegal_op11", {31'b0, csr_illegal_o});
    tick();
    csr_wena_i = 1'b0;
    read_chk("mcause_kept", CSR_MCAUSE, 32'd11);
    exp_q.push_back(32'd1);
    csr_rena_i = 1'b1; csr_raddr_i = 12'h123; #1;
    check("illegal_read", {31'b0, csr_illegal_o});
    csr_rena_i = 1'b0;
    read_chk("unimpl_rdata", 12'h123, 32'h0);

    // Retire counting, then reset mid-run
    for (int i = 0; i < 20; i++) begin
      retire_i = (i == 2 || i == 5 || i == 9 || i == 13 || i == 17);
      tick();
    end
    retire_i = 1'b0;
    read_chk("minstret", CSR_MINSTRET, 32'd5);
    read_chk("minstreth", CSR_MINSTRETH, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    retire_i = 1'b1;
    tick();
    reset = 1'b0;
    retire_i = 1'b0;
    read_chk("rst_mcycle", CSR_MCYCLE, 32'h0);
    read_chk("rst_mcycleh", CSR_MCYCLEH, 32'h0);
    read_chk("rst_minstret", CSR_MINSTRET, 32'h0);
    read_chk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    read_chk("rst_mepc", CSR_MEPC, 32'h0);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: observed=%0d leftover expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
